mnist_pixel_packer: RTL and testbench

- Upstream stage of ens0_layer0. Accepts the MNIST pixel stream, one 8-bit pixel per handshake.
- Binarizes each pixel against a threshold and packs one full image into a registered PIXELS-bit vector.
- Presents that vector to the layer-0 neuron LUTs through a valid/ready handshake, so the combinational network sees a stable input word for a whole frame.
- Checks frame length against s_last and flags short and long frames.

---
 rtl/mnist_pixel_packer.sv | 108 ++++++++++
 tb/tb_mnist_pixel_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_pixel_packer.sv
// Binarizes an 8-bit MNIST pixel stream and packs each frame into a registered
// PIXELS-bit word for the layer-0 neuron LUTs, with short/long frame detection.
module mnist_pixel_packer #(
    parameter int PIXELS = 784,
    parameter int PIX_W  = 8,
    parameter int THRESH = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIXELS-1:0] m_data,
    output logic              err_short,
    output logic              err_long,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int IDX_W = $clog2(PIXELS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS - 1);

    typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             mv_nxt, es_nxt, el_nxt, cnt_inc, wr_en;
    logic             accept, m_fire;

    function automatic logic binarize(input logic [PIX_W-1:0] pix);
        return {1'b0, pix} >= (PIX_W+1)'(THRESH);
    endfunction

    // s_ready depends only on the state register, never on m_ready.
    assign s_ready = (state != HOLD);
    assign accept  = s_valid & s_ready;
    assign m_fire  = m_valid & m_ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mv_nxt    = m_valid;
        es_nxt    = 1'b0;
        el_nxt    = 1'b0;
        cnt_inc   = 1'b0;
        wr_en     = 1'b0;

        if (m_fire) begin
            mv_nxt  = 1'b0;
            cnt_inc = 1'b1;
        end

        case (state)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        mv_nxt    = 1'b1;
                        state_nxt = s_last ? HOLD : DRAIN;
                        el_nxt    = ~s_last;
                    end else if (s_last) begin
                        idx_nxt = '0;
                        es_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Once the frame has been taken during the drain, finish in FILL.
                if (accept && s_last)
                    state_nxt = (m_valid && !m_ready) ? HOLD : FILL;
            end
            HOLD: begin
                if (m_fire)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            m_valid   <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            frame_cnt <= '0;
            m_data    <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            m_valid   <= mv_nxt;
            err_short <= es_nxt;
            err_long  <= el_nxt;
            if (cnt_inc)
                frame_cnt <= frame_cnt + 1'b1;
            if (wr_en)
                m_data[idx] <= binarize(s_data);
        end
    end

endmodule

// File: tb/tb_mnist_pixel_packer.sv
// Directed/randomized bench for mnist_pixel_packer against a frame-level model.
module tb_mnist_pixel_packer;

    localparam int PIXELS = 784;
    localparam int PIX_W  = 8;
    localparam int THRESH = 128;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [PIX_W-1:0]  s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [PIXELS-1:0] m_data;
    logic              err_short;
    logic              err_long;
    logic [CNT_W-1:0]  frame_cnt;

    mnist_pixel_packer #(
        .PIXELS(PIXELS), .PIX_W(PIX_W), .THRESH(THRESH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks  = 0;
    int passed  = 0;
    int exp_cnt = 0;
    logic [PIXELS-1:0] exp_bits = '0;
    logic [7:0]        pix [0:799];

    task automatic chk(input string tag, input logic [PIXELS-1:0] obs,
                       input logic [PIXELS-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [CNT_W-1:0] cnt_model();
        return CNT_W'(exp_cnt % (1 << CNT_W));
    endfunction

    // Frame model: pixel values plus the expected packed word of the first PIXELS.
    task automatic gen(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       pix[i] = (i % 2 == 0) ? 8'h80 : 8'h7F;
                2:       pix[i] = 8'hFF;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       pix[i] = 8'(THRESH);
                        1:       pix[i] = 8'(THRESH - 1);
                        default: pix[i] = 8'($urandom_range(0, 255));
                    endcase
                end
            endcase
        end
        if (n >= PIXELS)
            for (int i = 0; i < PIXELS; i++)
                exp_bits[i] = (int'(pix[i]) >= THRESH);
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic last, output bit ok);
        int   n = 0;
        logic acc;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (n < 50) begin
            acc = s_ready;
            @(posedge clk); #1;
            n++;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("s_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input int n, input int mode, output int first_cyc);
        bit   ok;
        logic exp_mv;
        gen(n, mode);
        first_cyc = 0;
        for (int i = 0; i < n; i++) begin
            send_pixel(pix[i], (i == n - 1), ok);
            if (i == 0) first_cyc = cyc;
            if (i < PIXELS - 1)       exp_mv = 1'b0;
            else if (i == PIXELS - 1) exp_mv = 1'b1;
            else                      exp_mv = !m_ready;
            chk("pix_ctrl", {m_valid, err_short, err_long},
                {exp_mv, (i == n - 1 && n < PIXELS), (i == PIXELS - 1 && n > PIXELS)});
            if (i == PIXELS - 1) chk("m_data_frame", m_data, exp_bits);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (n > PIXELS && m_ready) begin
            exp_cnt++;
            chk("drain_cnt", frame_cnt, cnt_model());
        end
    endtask

    task automatic deliver(input int hold);
        chk("mv_after_last", m_valid, 1);
        chk("m_data_hold0", m_data, exp_bits);
        if (hold > 0) m_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("bp_ctrl", {s_ready, m_valid}, 2'b01);
            chk("bp_data", m_data, exp_bits);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        chk("mv_drop", {m_valid, s_ready}, 2'b01);
        chk("frame_cnt", frame_cnt, cnt_model());
        m_ready = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        chk({tag, "_ctrl"}, {m_valid, err_short, err_long}, 3'b000);
        chk({tag, "_cnt"}, frame_cnt, 0);
        chk({tag, "_data"}, m_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk({tag, "_s_ready"}, s_ready, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int fc;
        int fcs [0:2];
        bit ok;
        logic [PIXELS-1:0] alt;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        do_reset("reset");

        // Nominal alternating frame, m_ready held high.
        m_ready = 1'b1;
        send_frame(PIXELS, 1, fc);
        for (int i = 0; i < PIXELS; i++) alt[i] = (i % 2 == 0);
        chk("alt_bits", m_data, alt);
        deliver(0);

        // Backpressure for 20 cycles.
        m_ready = 1'b0;
        send_frame(PIXELS, 0, fc);
        deliver(20);

        // Short frame, then an all-ones frame.
        send_frame(11, 0, fc);
        @(posedge clk); #1;
        chk("short_pulse_end", {err_short, m_valid}, 2'b00);
        send_frame(PIXELS, 2, fc);
        chk("all_ones", m_data, '1);
        deliver(0);

        // Long frame held in HOLD; frame_cnt wraps to 0 here.
        m_ready = 1'b0;
        send_frame(790, 0, fc);
        deliver(3);
        chk("wrap_after_long", frame_cnt, 0);
        send_frame(PIXELS, 0, fc);
        deliver(0);

        // Long frame taken during the drain, ends back in FILL.
        m_ready = 1'b1;
        send_frame(PIXELS + 2, 0, fc);
        chk("drain_to_fill", {s_ready, m_valid}, 2'b10);
        m_ready = 1'b0;

        // Reset mid-frame after 400 pixels.
        for (int i = 0; i < 400; i++) send_pixel(8'($urandom_range(0, 255)), 1'b0, ok);
        s_valid = 1'b0;
        do_reset("mid_reset");
        send_frame(PIXELS, 0, fc);
        deliver(2);

        // Back-to-back frames with continuous m_ready.
        do_reset("b2b_reset");
        for (int k = 0; k < 3; k++) begin
            m_ready = 1'b1;
            send_frame(PIXELS, 0, fcs[k]);
            @(posedge clk); #1;
            exp_cnt++;
            chk("b2b_drop", {m_valid, s_ready}, 2'b01);
            chk("b2b_cnt", frame_cnt, cnt_model());
            if (k > 0) chk("b2b_period", fcs[k] - fcs[k-1], 785);
        end
        chk("b2b_cnt3", frame_cnt, 3);
        m_ready = 1'b0;
        send_frame(PIXELS, 0, fc);
        deliver(0);
        chk("cnt_wrap", frame_cnt, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
